truth_table_sequencer: RTL
==========================

Name: truth_table_sequencer

Overview:
Sequencer for the shared two-input logic-function datapath (implication ~a|b, conjunction a&b, and similar gate units). On start, it drives every input combination onto the datapath, waits a settle interval, and samples each function output. It assembles a packed truth table per function and compares the result against an expected vector. It sits between the test/control layer and the gate modules, replacing hand-written stimulus sequences.

Parameters:
N_IN, 2, number of datapath inputs; vectors per run NVEC = 2**N_IN
N_FN, 2, number of function outputs sampled per vector
SETTLE, 1, cycles x_out is held before sampling (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a run; accepted only in IDLE
x_out  output  N_IN  input vector driven to the datapath; x_out = idx, MSB = first operand (x), LSB = y
fn_in  input  N_FN  datapath outputs; fn_in[f] = function f evaluated on x_out
exp_in  input  N_FN*NVEC  expected table; sampled at run end
table_out  output  N_FN*NVEC  captured table; bit f*NVEC+idx = fn_in[f] at vector idx
busy  output  1  high in DRIVE and SAMPLE
done  output  1  one-cycle pulse when run completes
match  output  1  registered (table_out == exp_in); valid from done, held until next start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, idx=0, settle count=0, x_out=0, table_out=0, busy=0, done=0, match=0. Reset mid-run aborts the run; no done pulse is produced.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: on start=1, clear table_out and match, set idx=0, load settle count = SETTLE-1, go to DRIVE. Otherwise hold all outputs.
- DRIVE: x_out = idx. Decrement settle count each cycle; when count==0, go to SAMPLE. DRIVE therefore lasts exactly SETTLE cycles.
- SAMPLE: for each f, table_out[f*NVEC+idx] <= fn_in[f]. If idx==NVEC-1, go to DONE and register match <= ({captured table} == exp_in), including the bits written this cycle. Otherwise, idx <= idx+1, reload settle count, go to DRIVE.
- DONE: done=1 for exactly this cycle; busy=0; go to IDLE. start is ignored in DONE.
- start while busy or in DONE: ignored, not queued.
- x_out holds the last vector (NVEC-1) after the run until the next start or reset.
- Latency: done is high 2**N_IN*(SETTLE+1) rising edges after the edge that accepts start. For the default configuration this is 8 edges.
- idx width: N_IN bits; idx does not wrap, because the run ends at NVEC-1.
- fn_in is treated as combinational from x_out; the settle wait covers datapath delay. No synchronizer is required.

Decomposition:
- Package tt_seq_pkg: state enum (IDLE, DRIVE, SAMPLE, DONE); function nvec(n_in) returning 2**n_in; localparam SETTLE_W = 4.
- One sub-module, tt_settle_timer: loadable down-counter with a zero flag. It is reused by other stimulus sequencers.
- The gate datapath stays external; the sequencer only owns x_out and captures fn_in.

Test Plan:
- Defaults, fn_in[0]=~x|y, fn_in[1]=x&y, exp_in=8'h8B, start pulse → x_out steps 0,1,2,3 holding 1 cycle each; done 8 edges after start; table_out=8'h8B; match=1.
- Same functions, exp_in=8'h8A → table_out=8'h8B, match=0; done still pulses exactly once.
- start held high for the entire run → exactly one run; done pulses once. The run restarts only because start is still high in IDLE after DONE, and the bench checks table_out is cleared at that restart.
- rst_n asserted while idx=2 in DRIVE → all outputs 0 immediately (asynchronous); no done. After release, a new start gives table_out=8'h8B and match=1.
- SETTLE=3, datapath with 2-cycle registered delay on fn_in → x_out held 3 cycles per vector; done 16 edges after start; table_out=8'h8B.
- N_IN=3, N_FN=1, fn_in[0]=x_out[2]&x_out[1]&x_out[0] → table_out=8'h80; done 16 edges after start.

Source files
------------

// File: rtl/tt_seq_pkg.sv
// Shared types and helpers for the truth-table stimulus sequencers.
package tt_seq_pkg;

  // Width of the settle down-counter; supports settle intervals of 1..15 cycles.
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Number of input vectors for an n_in-input datapath.
  function automatic int nvec(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter with a zero flag. It holds at zero, and a load
// takes priority over a decrement.
module tt_settle_timer
  import tt_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [SETTLE_W-1:0] count;

  // Counter register: load, or count down toward zero.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - SETTLE_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Drives every input combination onto an external two-input gate datapath.
// It waits SETTLE cycles per vector, samples each function output, and
// assembles a packed truth table. The table is compared with an expected
// vector at the end of the run.
module truth_table_sequencer
  import tt_seq_pkg::*;
#(
  parameter  int N_IN   = 2,
  parameter  int N_FN   = 2,
  parameter  int SETTLE = 1,
  localparam int NVEC   = nvec(N_IN),
  localparam int TW     = N_FN * NVEC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] x_out,
  input  logic [N_FN-1:0] fn_in,
  input  logic [TW-1:0]   exp_in,
  output logic [TW-1:0]   table_out,
  output logic            busy,
  output logic            done,
  output logic            match
);

  state_t              state;
  logic [N_IN-1:0]     idx;
  logic [TW-1:0]       table_q;
  logic [TW-1:0]       table_sampled;
  logic                match_q;
  logic                last_vec;
  logic                timer_load;
  logic                timer_dec;
  logic                timer_zero;
  logic [SETTLE_W-1:0] timer_val;

  assign last_vec  = (idx == {N_IN{1'b1}});
  assign timer_val = SETTLE_W'(SETTLE - 1);

  // Table with the current vector's function outputs merged in. Used both as
  // the next table value and as the operand of the final compare, so that the
  // compare sees the bits captured in the last SAMPLE cycle.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    table_sampled = table_q;
    for (int f = 0; f < N_FN; f++) begin
      for (int v = 0; v < NVEC; v++) begin
        if (v == int'(idx)) table_sampled[f*NVEC + v] = fn_in[f];
      end
    end
  end

  // Settle timer control: reload at the start of each vector, count in DRIVE.
  always_comb begin
    timer_load = ((state == IDLE) && start) || ((state == SAMPLE) && !last_vec);
    timer_dec  = (state == DRIVE);
  end

  tt_settle_timer u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // Sequencer FSM: walks idx through every vector and captures the table.
  // NOTE: all state is reset asynchronously, so a reset in the middle of a run leaves nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      table_q <= '0;
      match_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= DRIVE;
            idx     <= '0;
            table_q <= '0;
            match_q <= 1'b0;
          end
        end
        DRIVE: begin
          if (timer_zero) state <= SAMPLE;
        end
        SAMPLE: begin
          table_q <= table_sampled;
          if (last_vec) begin
            state   <= DONE;
            match_q <= (table_sampled == exp_in);
          end else begin
            idx   <= idx + N_IN'(1);
            state <= DRIVE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // x_out follows idx directly. It therefore holds the last vector after a run ends.
  assign x_out     = idx;
  assign table_out = table_q;
  assign match     = match_q;
  assign busy      = (state == DRIVE) || (state == SAMPLE);
  assign done      = (state == DONE);

endmodule
